// File: rtl/fault_sim_sequencer.sv
// Fault-simulation sequencer: golden pass, then one pass per fault, streaming per-fault detection vectors.
// Latency: each pass is 2**N_IN*(SETTLE+1) cycles; REPORT lasts >=1 cycle and a handshake can complete in its first cycle.
// Backpressure: REPORT holds all result outputs, pat_out and fault_en stable while res_ready is low.
module fault_sim_sequencer #(
  parameter int N_IN    = 3,
  parameter int N_FAULT = 5,
  parameter int SETTLE  = 1
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    start,
  output logic                                    busy,
  output logic                                    done,
  output logic [N_IN-1:0]                         pat_out,
  output logic [N_FAULT-1:0]                      fault_en,
  input  logic                                    dut_resp,
  output logic [(1<<N_IN)-1:0]                    golden,
  output logic                                    res_valid,
  input  logic                                    res_ready,
  output logic [(N_FAULT>1?$clog2(N_FAULT):1)-1:0] res_fault,
  output logic [(1<<N_IN)-1:0]                    res_detect,
  output logic [N_FAULT-1:0]                      fault_cov
);

  localparam int N_PAT = 1 << N_IN;
  localparam int FW    = (N_FAULT > 1) ? $clog2(N_FAULT) : 1;
  localparam int SW    = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_GOLD   = 3'd1;
  localparam logic [2:0] S_FAULT  = 3'd2;
  localparam logic [2:0] S_REPORT = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]       state;
  logic [N_IN-1:0]  pat;
  logic [SW-1:0]    cnt;
  logic [FW-1:0]    k;
  logic [N_PAT-1:0] golden_q;
  logic [N_PAT-1:0] det;
  logic [N_FAULT-1:0] cov_q;

  logic sample;
  logic last_pat;
  logic last_fault;

  // Pattern is sampled on the last cycle of its settle window.
  always_comb begin
    sample     = (cnt == SW'(SETTLE));
    last_pat   = (pat == N_IN'(N_PAT - 1));
    last_fault = (k == FW'(N_FAULT - 1));
  end

  // Main sequencing FSM: pattern stepping, golden capture, detect capture and result handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      pat      <= '0;
      cnt      <= '0;
      k        <= '0;
      golden_q <= '0;
      det      <= '0;
      cov_q    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_GOLD;
            cov_q    <= '0;
            golden_q <= '0;
            det      <= '0;
            pat      <= '0;
            cnt      <= '0;
            k        <= '0;
          end
        end
        S_GOLD: begin
          if (sample) begin
            golden_q[pat] <= dut_resp;
            cnt           <= '0;
            if (last_pat) begin
              state <= S_FAULT;
              k     <= '0;
              pat   <= '0;
            end else begin
              pat <= pat + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_FAULT: begin
          if (sample) begin
            det[pat] <= dut_resp ^ golden_q[pat];
            cnt      <= '0;
            // On the last pattern pat is left alone so pat_out holds through REPORT.
            if (last_pat) begin
              state <= S_REPORT;
            end else begin
              pat <= pat + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_REPORT: begin
          if (res_ready) begin
            cov_q[k] <= cov_q[k] | (|det);
            det      <= '0;
            if (last_fault) begin
              state <= S_DONE;
            end else begin
              k     <= k + 1'b1;
              pat   <= '0;
              cnt   <= '0;
              state <= S_FAULT;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Outputs decoded from registered state; fault injection only during a fault pass.
  always_comb begin
    busy       = (state != S_IDLE);
    done       = (state == S_DONE);
    res_valid  = (state == S_REPORT);
    fault_en   = (state == S_FAULT) ? (N_FAULT'(1) << k) : '0;
    pat_out    = pat;
    golden     = golden_q;
    res_fault  = k;
    res_detect = det;
    fault_cov  = cov_q;
  end

endmodule
